hazard_flush_ctrl: RTL and testbench
====================================

# hazard_flush_ctrl

- Drives the program counter's control inputs (`PC_write`, `IF_flush`, `pc_jump`, `pc_branch`, `alu_zero`, `j_address`, `br_address`) and the IF/ID and ID/EX pipeline-register controls.
- Resolves three event types with a fixed priority: EX-stage control-flow redirects, load-use hazards, and multi-cycle instruction-memory waits.
- A redirect resolved while a fetch is outstanding is latched and replayed once the fetch completes.
- Also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- `a_size`, 32, address width of the redirect targets
- `r_size`, 5, register-specifier width

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `id_rs`, `id_rt`  in  r_size  source registers of the instruction in ID
- `id_uses_rs`, `id_uses_rt`  in  1  the ID instruction reads `rs` / `rt`
- `ex_rd`  in  r_size  destination of the instruction in EX
- `ex_mem_read`  in  1  the EX instruction is a load
- `ex_jump`, `ex_branch`, `ex_alu_zero`  in  1  EX control-flow resolution
- `ex_j_address`, `ex_br_address`  in  a_size  EX targets
- `imem_ready`  in  1  the current fetch completes this cycle
- `PC_write`, `IF_flush`, `pc_jump`, `pc_branch`, `alu_zero`  out  1  to the PC
- `j_address`, `br_address`  out  a_size  to the PC
- `IFID_write`, `IFID_flush`, `IDEX_bubble`  out  1  pipeline-register controls
- `stall_count`, `flush_count`  out  16  performance counters

## Operation
Derived signals:
- `redirect = ex_jump | (ex_branch & ex_alu_zero)`. A not-taken branch is not a redirect.
- `load_use = ex_mem_read & (ex_rd != 0) & ((id_uses_rs & id_rs == ex_rd) | (id_uses_rt & id_rt == ex_rd))`.

States: RUN, PEND. Pending registers hold the latched `ex_jump`, `ex_branch`, `ex_alu_zero`, `ex_j_address` and `ex_br_address`.

RUN — the first matching row wins:
- `redirect & imem_ready`:
  - `IF_flush`=1.
  - `pc_jump`/`pc_branch`/`alu_zero`/`j_address`/`br_address` pass through from the `ex_*` inputs.
  - `IFID_flush`=1, `IDEX_bubble`=1, `PC_write`=0, `IFID_write`=0.
  - Stay in RUN.
- `redirect & !imem_ready`:
  - Latch the `ex_*` redirect fields into the pending registers.
  - `IF_flush`=0, `IFID_flush`=1, `IDEX_bubble`=1, `PC_write`=0, `IFID_write`=0.
  - Go to PEND.
- `load_use`: `PC_write`=0, `IFID_write`=0, `IDEX_bubble`=1 (one bubble per hazard cycle).
- `!imem_ready`: `PC_write`=0, `IFID_write`=0, `IDEX_bubble`=1.
- Otherwise: `PC_write`=1, `IFID_write`=1, all other controls 0.

PEND:
- All `ex_*` inputs are ignored; only older-instruction bubbles can reach EX, so a second redirect cannot be legal.
- `imem_ready`=1:
  - `IF_flush`=1, driven from the pending registers.
  - `IFID_flush`=1, `IDEX_bubble`=1, `PC_write`=0, `IFID_write`=0.
  - Go to RUN.
- `imem_ready`=0: `PC_write`=0, `IFID_write`=0, `IFID_flush`=0, `IDEX_bubble`=1. Stay in PEND.

Output defaults:
- Whenever `IF_flush`=0, the `pc_jump`, `pc_branch` and `alu_zero` outputs are 0.
- Whenever `IF_flush`=0, `j_address`/`br_address` are driven from the `ex_*` inputs in RUN and from the pending registers in PEND.

Counters (16-bit, saturating at 0xFFFF, never wrap):
- `stall_count` increments on each clock edge where `PC_write`=0 and `IF_flush`=0.
- `flush_count` increments on each clock edge where `IF_flush`=1.

## Timing
- All control outputs are combinational from the current state and inputs. The PC samples them at the same rising edge, so redirect latency is 0 cycles in RUN.
- A pending redirect is replayed in the first cycle of PEND with `imem_ready`=1. Total delay is N+1 cycles for an N-cycle wait after the resolving cycle.
- Reset (asynchronous, any time, including mid-PEND):
  - state → RUN;
  - pending registers → 0;
  - `stall_count` and `flush_count` → 0.
- While `rst`=1, all 1-bit control outputs are 0, `j_address` and `br_address` are 0, and the counters do not count.
- After `rst` falls, the first edge behaves as RUN. A pending redirect lost to reset is not replayed.
- Redirect and load-use in the same cycle: the redirect wins and no extra stall is inserted.
- Load-use and `!imem_ready` in the same cycle: the controls are identical, and one stall cycle is counted.
- `ex_rd`=0 never produces a load-use hazard.

## Test plan
- Reset mid-PEND (latched target 0x40): state returns to RUN, counters are 0, and the next `imem_ready`=1 cycle gives `PC_write`=1 with no `IF_flush`.
- Load in EX with `ex_rd`=5, ID `id_rs`=5, `id_uses_rs`=1, `imem_ready`=1 → one cycle of `PC_write`=0, `IFID_write`=0, `IDEX_bubble`=1; `stall_count`=1. With `ex_rd`=0 → no stall.
- `ex_jump`=1, `ex_j_address`=0x80, `imem_ready`=1 → same-cycle `IF_flush`=1, `pc_jump`=1, `j_address`=0x80, `IFID_flush`=1; `flush_count`=1.
- `ex_branch`=1, `ex_alu_zero`=0 → no flush, `PC_write`=1. The same branch with `ex_alu_zero`=1 and `ex_br_address`=0x24 → `IF_flush`=1, `pc_branch`=1, `alu_zero`=1, `br_address`=0x24.
- Taken branch to 0x30 with `imem_ready`=0, then `ex_jump` pulsed while in PEND, then 3 wait cycles → no `IF_flush` during the wait. The cycle `imem_ready` rises gives `IF_flush`=1, `br_address`=0x30, `pc_jump`=0; return to RUN; `stall_count`=4.
- Hold `imem_ready`=0 for 70000 cycles → `stall_count` saturates at 0xFFFF and does not wrap.

Source files
------------

// File: rtl/hazard_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_flush_ctrl
// Purpose  : Pipeline hazard and flush controller. Resolves, in fixed
//            priority order, EX-stage control-flow redirects, load-use
//            hazards and multi-cycle instruction-memory waits. Drives the
//            program-counter control inputs and the IF/ID and ID/EX
//            pipeline-register controls. A redirect resolved while a fetch
//            is still outstanding is latched and replayed once the fetch
//            completes. Also keeps saturating stall and flush counters.
//
// Ports    :
//   clk, rst             clock; asynchronous active-high reset
//   id_rs, id_rt         source registers of the instruction in ID
//   id_uses_rs/rt        the ID instruction actually reads rs / rt
//   ex_rd                destination register of the instruction in EX
//   ex_mem_read          the EX instruction is a load
//   ex_jump/branch/      EX control-flow resolution
//   ex_alu_zero
//   ex_j/br_address      EX redirect targets
//   imem_ready           the current fetch completes this cycle
//   PC_write, IF_flush,  program-counter controls
//   pc_jump, pc_branch,
//   alu_zero, j_address,
//   br_address
//   IFID_write,          pipeline-register controls
//   IFID_flush,
//   IDEX_bubble
//   stall_count,         16-bit saturating performance counters
//   flush_count
//
// Revision : 1.0 - initial release
// ============================================================================
module hazard_flush_ctrl #(
   parameter int a_size = 32,
   parameter int r_size = 5
) (
   input  logic              clk,
   input  logic              rst,
   // ID-stage operands
   input  logic [r_size-1:0] id_rs,
   input  logic [r_size-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   // EX-stage producer / control flow
   input  logic [r_size-1:0] ex_rd,
   input  logic              ex_mem_read,
   input  logic              ex_jump,
   input  logic              ex_branch,
   input  logic              ex_alu_zero,
   input  logic [a_size-1:0] ex_j_address,
   input  logic [a_size-1:0] ex_br_address,
   // Instruction memory handshake
   input  logic              imem_ready,
   // Program-counter controls
   output logic              PC_write,
   output logic              IF_flush,
   output logic              pc_jump,
   output logic              pc_branch,
   output logic              alu_zero,
   output logic [a_size-1:0] j_address,
   output logic [a_size-1:0] br_address,
   // Pipeline-register controls
   output logic              IFID_write,
   output logic              IFID_flush,
   output logic              IDEX_bubble,
   // Performance counters
   output logic [15:0]       stall_count,
   output logic [15:0]       flush_count
);

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_PEND = 1'b1
   } state_t;

   localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

   state_t            state_q, state_d;

   // Redirect captured while a fetch was outstanding
   logic              pend_jump_q,   pend_jump_d;
   logic              pend_branch_q, pend_branch_d;
   logic              pend_zero_q,   pend_zero_d;
   logic [a_size-1:0] pend_j_addr_q, pend_j_addr_d;
   logic [a_size-1:0] pend_br_addr_q, pend_br_addr_d;

   logic [15:0]       stall_q, flush_q;

   logic              w_redirect;
   logic              w_rs_hit;
   logic              w_rt_hit;
   logic              w_load_use;

   // ------------------------------------------------------------------------
   // Hazard detection
   // ------------------------------------------------------------------------
   // A not-taken branch is not a redirect.
   assign w_redirect = ex_jump | (ex_branch & ex_alu_zero);

   // Register 0 is hard-wired, so a load targeting it never creates a hazard.
   assign w_rs_hit   = id_uses_rs & (id_rs == ex_rd);
   assign w_rt_hit   = id_uses_rt & (id_rt == ex_rd);
   assign w_load_use = ex_mem_read & (ex_rd != '0) & (w_rs_hit | w_rt_hit);

   // ------------------------------------------------------------------------
   // State and pending-redirect registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_RUN;
         pend_jump_q    <= 1'b0;
         pend_branch_q  <= 1'b0;
         pend_zero_q    <= 1'b0;
         pend_j_addr_q  <= '0;
         pend_br_addr_q <= '0;
      end else begin
         state_q        <= state_d;
         pend_jump_q    <= pend_jump_d;
         pend_branch_q  <= pend_branch_d;
         pend_zero_q    <= pend_zero_d;
         pend_j_addr_q  <= pend_j_addr_d;
         pend_br_addr_q <= pend_br_addr_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------------
   // All controls are combinational so the PC can act on a redirect at the
   // same edge it is resolved. While rst is high every output is forced low.
   always_comb begin
      state_d        = state_q;
      pend_jump_d    = pend_jump_q;
      pend_branch_d  = pend_branch_q;
      pend_zero_d    = pend_zero_q;
      pend_j_addr_d  = pend_j_addr_q;
      pend_br_addr_d = pend_br_addr_q;

      PC_write       = 1'b0;
      IF_flush       = 1'b0;
      pc_jump        = 1'b0;
      pc_branch      = 1'b0;
      alu_zero       = 1'b0;
      j_address      = '0;
      br_address     = '0;
      IFID_write     = 1'b0;
      IFID_flush     = 1'b0;
      IDEX_bubble    = 1'b0;

      if (!rst) begin
         case (state_q)
            ST_RUN: begin
               j_address  = ex_j_address;
               br_address = ex_br_address;
               if (w_redirect && imem_ready) begin
                  // Redirect taken immediately; wrong-path fetch and the
                  // instruction in ID are discarded.
                  IF_flush    = 1'b1;
                  pc_jump     = ex_jump;
                  pc_branch   = ex_branch;
                  alu_zero    = ex_alu_zero;
                  IFID_flush  = 1'b1;
                  IDEX_bubble = 1'b1;
               end else if (w_redirect) begin
                  // The PC cannot move until the outstanding fetch returns,
                  // so hold the redirect and replay it later.
                  pend_jump_d    = ex_jump;
                  pend_branch_d  = ex_branch;
                  pend_zero_d    = ex_alu_zero;
                  pend_j_addr_d  = ex_j_address;
                  pend_br_addr_d = ex_br_address;
                  IFID_flush     = 1'b1;
                  IDEX_bubble    = 1'b1;
                  state_d        = ST_PEND;
               end else if (w_load_use || !imem_ready) begin
                  // Load-use and fetch wait share identical controls.
                  IDEX_bubble = 1'b1;
               end else begin
                  PC_write   = 1'b1;
                  IFID_write = 1'b1;
               end
            end

            ST_PEND: begin
               // EX holds only bubbles here, so ex_* are ignored.
               j_address   = pend_j_addr_q;
               br_address  = pend_br_addr_q;
               IDEX_bubble = 1'b1;
               if (imem_ready) begin
                  IF_flush   = 1'b1;
                  pc_jump    = pend_jump_q;
                  pc_branch  = pend_branch_q;
                  alu_zero   = pend_zero_q;
                  IFID_flush = 1'b1;
                  state_d    = ST_RUN;
               end
            end

            default: begin
               state_d = ST_RUN;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Saturating performance counters
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else if (!PC_write && !IF_flush && (stall_q != c_CNT_MAX)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flush_q <= '0;
      end else if (IF_flush && (flush_q != c_CNT_MAX)) begin
         flush_q <= flush_q + 16'd1;
      end
   end

   assign stall_count = stall_q;
   assign flush_count = flush_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_flush_ctrl
// Purpose  : Directed self-checking bench for hazard_flush_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_flush_ctrl;

   localparam int c_A = 32;
   localparam int c_R = 5;

   logic           clk;
   logic           rst;
   logic [c_R-1:0] id_rs, id_rt, ex_rd;
   logic           id_uses_rs, id_uses_rt, ex_mem_read;
   logic           ex_jump, ex_branch, ex_alu_zero;
   logic [c_A-1:0] ex_j_address, ex_br_address;
   logic           imem_ready;
   logic           PC_write, IF_flush, pc_jump, pc_branch, alu_zero;
   logic [c_A-1:0] j_address, br_address;
   logic           IFID_write, IFID_flush, IDEX_bubble;
   logic [15:0]    stall_count, flush_count;

   int n_cmp = 0;
   int n_err = 0;

   hazard_flush_ctrl #(.a_size(c_A), .r_size(c_R)) dut (
      .clk           (clk),
      .rst           (rst),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .id_uses_rs    (id_uses_rs),
      .id_uses_rt    (id_uses_rt),
      .ex_rd         (ex_rd),
      .ex_mem_read   (ex_mem_read),
      .ex_jump       (ex_jump),
      .ex_branch     (ex_branch),
      .ex_alu_zero   (ex_alu_zero),
      .ex_j_address  (ex_j_address),
      .ex_br_address (ex_br_address),
      .imem_ready    (imem_ready),
      .PC_write      (PC_write),
      .IF_flush      (IF_flush),
      .pc_jump       (pc_jump),
      .pc_branch     (pc_branch),
      .alu_zero      (alu_zero),
      .j_address     (j_address),
      .br_address    (br_address),
      .IFID_write    (IFID_write),
      .IFID_flush    (IFID_flush),
      .IDEX_bubble   (IDEX_bubble),
      .stall_count   (stall_count),
      .flush_count   (flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
      ex_rd = '0; ex_mem_read = 1'b0;
      ex_jump = 1'b0; ex_branch = 1'b0; ex_alu_zero = 1'b0;
      ex_j_address = '0; ex_br_address = '0;
      imem_ready = 1'b1;
   endtask

   // Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #1;
      rst = 1'b0;
      idle_inputs();
      #1;
   endtask

   initial begin
      // ---------------- reset state ----------------
      idle_inputs();
      rst = 1'b1;
      ex_jump = 1'b1; ex_j_address = 32'h1234;
      #1;
      check_val("rst_PC_write", PC_write, 0);
      check_val("rst_IF_flush", IF_flush, 0);
      check_val("rst_pc_jump", pc_jump, 0);
      check_val("rst_j_address", j_address, 0);
      check_val("rst_IDEX_bubble", IDEX_bubble, 0);
      repeat (2) step();
      check_val("rst_stall_count", stall_count, 0);
      check_val("rst_flush_count", flush_count, 0);
      rst = 1'b0;
      idle_inputs();
      #1;

      // ---------------- reset mid-PEND ----------------
      ex_branch = 1'b1; ex_alu_zero = 1'b1; ex_br_address = 32'h40;
      imem_ready = 1'b0;
      #1;
      check_val("pendA_IF_flush", IF_flush, 0);
      step();
      idle_inputs(); imem_ready = 1'b0;
      #1;
      check_val("pendA_br_address", br_address, 32'h40);
      check_val("pendA_stall", stall_count, 1);
      rst = 1'b1;
      #1;
      check_val("rstpend_stall", stall_count, 0);
      check_val("rstpend_PC_write", PC_write, 0);
      rst = 1'b0;
      imem_ready = 1'b1;
      #1;
      check_val("afterrst_PC_write", PC_write, 1);
      check_val("afterrst_IF_flush", IF_flush, 0);
      check_val("afterrst_br_address", br_address, 0);
      step();
      check_val("afterrst_flush_cnt", flush_count, 0);
      check_val("afterrst_stall_cnt", stall_count, 0);

      // ---------------- load-use ----------------
      pulse_reset();
      ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
      #1;
      check_val("lu_PC_write", PC_write, 0);
      check_val("lu_IFID_write", IFID_write, 0);
      check_val("lu_IDEX_bubble", IDEX_bubble, 1);
      step();
      check_val("lu_stall_count", stall_count, 1);
      ex_rd = 5'd0; id_rs = 5'd0;
      #1;
      check_val("lu_rd0_PC_write", PC_write, 1);
      check_val("lu_rd0_IDEX_bubble", IDEX_bubble, 0);
      step();
      check_val("lu_rd0_stall_count", stall_count, 1);
      // rt path, and rt match ignored when rt is unused
      ex_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1; id_uses_rs = 1'b0;
      #1;
      check_val("lu_rt_PC_write", PC_write, 0);
      id_uses_rt = 1'b0;
      #1;
      check_val("lu_rt_unused_PC_write", PC_write, 1);
      // load-use together with a fetch wait counts one stall
      id_uses_rt = 1'b1; imem_ready = 1'b0;
      #1;
      check_val("lu_wait_IDEX_bubble", IDEX_bubble, 1);
      step();
      check_val("lu_wait_stall_count", stall_count, 2);
      idle_inputs();

      // ---------------- jump, redirect beats load-use ----------------
      pulse_reset();
      ex_jump = 1'b1; ex_j_address = 32'h80;
      ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs = 5'd3; id_uses_rs = 1'b1;
      #1;
      check_val("jmp_IF_flush", IF_flush, 1);
      check_val("jmp_pc_jump", pc_jump, 1);
      check_val("jmp_pc_branch", pc_branch, 0);
      check_val("jmp_j_address", j_address, 32'h80);
      check_val("jmp_IFID_flush", IFID_flush, 1);
      check_val("jmp_IDEX_bubble", IDEX_bubble, 1);
      check_val("jmp_PC_write", PC_write, 0);
      step();
      check_val("jmp_flush_count", flush_count, 1);
      check_val("jmp_stall_count", stall_count, 0);
      idle_inputs();

      // ---------------- branch not taken / taken ----------------
      ex_branch = 1'b1; ex_alu_zero = 1'b0; ex_br_address = 32'h24;
      #1;
      check_val("bnt_IF_flush", IF_flush, 0);
      check_val("bnt_PC_write", PC_write, 1);
      check_val("bnt_pc_branch", pc_branch, 0);
      ex_alu_zero = 1'b1;
      #1;
      check_val("bt_IF_flush", IF_flush, 1);
      check_val("bt_pc_branch", pc_branch, 1);
      check_val("bt_alu_zero", alu_zero, 1);
      check_val("bt_br_address", br_address, 32'h24);
      step();
      check_val("bt_flush_count", flush_count, 2);
      idle_inputs();

      // ---------------- redirect during fetch wait ----------------
      pulse_reset();
      ex_branch = 1'b1; ex_alu_zero = 1'b1; ex_br_address = 32'h30;
      imem_ready = 1'b0;
      #1;
      check_val("pend_res_IF_flush", IF_flush, 0);
      check_val("pend_res_IFID_flush", IFID_flush, 1);
      check_val("pend_res_PC_write", PC_write, 0);
      step();
      idle_inputs(); imem_ready = 1'b0;
      ex_jump = 1'b1; ex_j_address = 32'h99;
      #1;
      check_val("pend_w1_IF_flush", IF_flush, 0);
      check_val("pend_w1_IFID_flush", IFID_flush, 0);
      check_val("pend_w1_IDEX_bubble", IDEX_bubble, 1);
      check_val("pend_w1_pc_jump", pc_jump, 0);
      step();
      ex_jump = 1'b0; ex_j_address = '0;
      for (int i = 0; i < 2; i++) begin
         #1;
         check_val("pend_wn_IF_flush", IF_flush, 0);
         check_val("pend_wn_PC_write", PC_write, 0);
         step();
      end
      imem_ready = 1'b1;
      #1;
      check_val("pend_rep_IF_flush", IF_flush, 1);
      check_val("pend_rep_br_address", br_address, 32'h30);
      check_val("pend_rep_pc_branch", pc_branch, 1);
      check_val("pend_rep_alu_zero", alu_zero, 1);
      check_val("pend_rep_pc_jump", pc_jump, 0);
      check_val("pend_rep_IFID_flush", IFID_flush, 1);
      step();
      check_val("pend_stall_count", stall_count, 4);
      check_val("pend_flush_count", flush_count, 1);
      #1;
      check_val("pend_back_PC_write", PC_write, 1);
      check_val("pend_back_IF_flush", IF_flush, 0);

      // ---------------- stall counter saturation ----------------
      pulse_reset();
      imem_ready = 1'b0;
      repeat (70000) @(posedge clk);
      #1;
      check_val("sat_stall_count", stall_count, 32'hFFFF);
      step();
      step();
      check_val("sat_hold_stall_count", stall_count, 32'hFFFF);
      check_val("sat_flush_count", flush_count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
